bcrypt_core_port: RTL
=====================

// Module: bcrypt_core_port
// PURPOSE
//  Per-core responder for the arbiter's start/done handshake over the shared BRAM port A.
//  - start=1: fetch this core's input words from BRAM.
//  - start=2: run the attached compute engine.
//  - start=3: write this core's results back to BRAM.
//  One instance sits in front of each bcrypt compute engine. Its WE/Addr/WrData are muxed to BRAM by the arbiter.
// PARAMETERS
//  CORE_STRIDE  32'd136  bytes between consecutive cores' input regions (base = core_id*CORE_STRIDE)
//  LOAD_WORDS   32       32-bit words fetched per load (range 1..64)
//  STORE_WORDS  6        32-bit result words written per store (range 1..16)
//  OFFSET       32'd4260 byte base of result region; core region = OFFSET + core_id*4*STORE_WORDS
//  READ_LAT     2        cycles from Addr_A change to matching RdData (1 arbiter register + 1 BRAM)
// PORTS
//  clk        in   1   clock; all logic on posedge
//  rst        in   1   synchronous, active-high reset
//  core_id    in   8   static core index
//  start      in   32  command from arbiter: 0 idle, 1 load, 2 compute, 3 store
//  done       out  32  status to arbiter: 0 idle/busy, 1 loaded, 2 computed, 32'hFF stored
//  WE_A       out  4   byte write enables toward arbiter mux
//  Addr_A     out  32  byte address toward arbiter mux
//  WrData_A   out  32  write data toward arbiter mux
//  RdData_A   in   32  shared BRAM read data
//  cmp_start  out  1   one-cycle pulse that starts the compute engine
//  cmp_done   in   1   one-cycle pulse from engine when finished
//  ld_raddr   in   6   engine read address into load buffer
//  ld_rdata   out  32  load-buffer data; combinational from ld_raddr
//  res_we     in   1   engine write strobe into result buffer
//  res_waddr  in   4   result-buffer write address
//  res_wdata  in   32  result-buffer write data
// BEHAVIOUR
//  Reset: state IDLE; done=0; WE_A=0; Addr_A=0; WrData_A=0; cmp_start=0; last_cmd=0. Buffers keep contents.
//  Command acceptance:
//   - A command is accepted only in IDLE/HOLD, and only when start != last_cmd.
//   - On acceptance, last_cmd <= start and done <= 0 in the same cycle.
//   - The arbiter holds start for a long time, so commands are edge-on-value, never level.
//  States:
//   - IDLE: bus outputs 0.
//   - LOAD:
//     - Cycle k (0..LOAD_WORDS-1): Addr_A = core_id*CORE_STRIDE + 4k, WE_A = 0.
//     - The word for cycle k arrives on RdData_A at k+READ_LAT and is written to buffer[k].
//   - LDRAIN: wait READ_LAT cycles, then done <= 1 and go to HOLD.
//   - COMPUTE: cmp_start is high for exactly one cycle on entry. Wait for cmp_done, then done <= 2 and go to HOLD.
//   - STORE:
//     - Cycle k (0..STORE_WORDS-1): WE_A = 4'hF, Addr_A = OFFSET + core_id*4*STORE_WORDS + 4k, WrData_A = res[k].
//     - Then one settle cycle with bus outputs 0.
//     - Then done <= 32'hFF and go to HOLD.
//   - HOLD: done holds its value. start=0 returns to IDLE, with done <= 0 and last_cmd <= 0.
//  Boundary rules:
//   - Bus outputs are all zero outside LOAD and STORE.
//   - start changes during LOAD/LDRAIN/COMPUTE/STORE are ignored. They are re-evaluated on the next HOLD cycle.
//   - Codes 4..0xFFFFFFFF are ignored; state and done are unchanged.
//   - start=2 with no prior load is legal: the engine runs on stale buffer contents.
//   - start=3 with no prior compute is legal: stale results are written.
//   - cmp_done outside COMPUTE is ignored.
//   - A res_we write during STORE to the address being read returns the old data (read-before-write).
//   - Reset in any state aborts at once: no further writes, done=0. A partly written region is not rolled back.
//  Latency:
//   - load: accept -> done=1 in LOAD_WORDS+READ_LAT+1 cycles.
//   - store: accept -> done=FF in STORE_WORDS+2 cycles.
// STRUCTURE
//  Shared include bcrypt_defs.vh:
//   - command codes CMD_IDLE/LOAD/COMPUTE/STORE
//   - status codes ST_LOADED/COMPUTED/STORED
//   - state encoding
//   - OFFSET default
//  Sub-module bcrypt_word_buf: 1 write port and 1 async read port register file, parameterised by depth.
//   - Instantiated twice: load buffer (LOAD_WORDS) and result buffer (STORE_WORDS).
//  Top level: FSM, address counter, READ_LAT delay line for the write-index/valid.
// TESTING
//  1 core_id=3, start 0->1, BRAM model preloaded word[i]=i+0x100 at 408+4i:
//    Addr_A sweeps 408..532; ld_rdata(5)=0x105; done=1 exactly 35 cycles after start change.
//  2 Hold start=1 for 200 cycles after done=1:
//    no new Addr_A activity; done stays 1.
//  3 start 1->2:
//    single cmp_start pulse; cmp_done after 50 cycles -> done=2 next cycle; spurious cmp_done in HOLD is ignored.
//  4 res[k]=0xA0+k, core_id=3, start 2->3:
//    writes at 4332..4352 with WE_A=F, data A0..A5; done=FF 8 cycles after start change.
//  5 start=3 -> 0:
//    done=0 and IDLE the next cycle; start=5 is ignored; start=2 mid-LOAD is deferred until done=1.
//  6 rst asserted on the 3rd STORE write:
//    outputs zero the next cycle; only words 0..1 are written; done=0.

Source files
------------

// File: rtl/bcrypt_core_port_pkg.sv
// Shared definitions for the bcrypt core port: command/status codes,
// default geometry, FSM state encoding and a command-validity helper.
package bcrypt_core_port_pkg;

  // Commands driven by the arbiter on start
  localparam logic [31:0] CMD_IDLE    = 32'd0;
  localparam logic [31:0] CMD_LOAD    = 32'd1;
  localparam logic [31:0] CMD_COMPUTE = 32'd2;
  localparam logic [31:0] CMD_STORE   = 32'd3;

  // Status codes reported back on done
  localparam logic [31:0] ST_IDLE     = 32'd0;
  localparam logic [31:0] ST_LOADED   = 32'd1;
  localparam logic [31:0] ST_COMPUTED = 32'd2;
  localparam logic [31:0] ST_STORED   = 32'hFF;

  // Default geometry of the shared BRAM layout
  localparam logic [31:0] DEF_CORE_STRIDE = 32'd136;
  localparam logic [31:0] DEF_OFFSET      = 32'd4260;
  localparam int          DEF_LOAD_WORDS  = 32;
  localparam int          DEF_STORE_WORDS = 6;
  localparam int          DEF_READ_LAT    = 2;

  // Buffer address widths and word counter width (covers 0..64)
  localparam int LD_AW  = 6;
  localparam int RES_AW = 4;
  localparam int CNT_W  = 7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LDRAIN,
    S_COMPUTE,
    S_STORE,
    S_SETTLE,
    S_HOLD
  } state_t;

  // Only load/compute/store start work; every other code is ignored
  function automatic logic is_work_cmd(input logic [31:0] code);
    return (code == CMD_LOAD) || (code == CMD_COMPUTE) || (code == CMD_STORE);
  endfunction

endpackage

// File: rtl/bcrypt_word_buf.sv
// Small register file: one synchronous write port, one asynchronous read
// port. Reads outside DEPTH return zero; writes outside DEPTH are dropped.
module bcrypt_word_buf #(
  parameter int DEPTH = 32,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [2**AW];

  // Write port; a same-cycle read of the written entry still sees old data
  // NOTE: storage is deliberately not reset; only control state needs a known value.
  always_ff @(posedge clk) begin
    if (we && (32'(waddr) < 32'(DEPTH))) begin
      mem[waddr] <= wdata;
    end
  end

  // Asynchronous read port
  always_comb begin
    rdata = (32'(raddr) < 32'(DEPTH)) ? mem[raddr] : 32'd0;
  end

endmodule

// File: rtl/bcrypt_core_port.sv
// Per-core responder to the arbiter's start/done handshake. Loads input
// words from BRAM, kicks the compute engine, and writes results back.
module bcrypt_core_port
  import bcrypt_core_port_pkg::*;
#(
  parameter logic [31:0] CORE_STRIDE = DEF_CORE_STRIDE,
  parameter int          LOAD_WORDS  = DEF_LOAD_WORDS,
  parameter int          STORE_WORDS = DEF_STORE_WORDS,
  parameter logic [31:0] OFFSET      = DEF_OFFSET,
  parameter int          READ_LAT    = DEF_READ_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        core_id,
  input  logic [31:0]       start,
  output logic [31:0]       done,
  output logic [3:0]        WE_A,
  output logic [31:0]       Addr_A,
  output logic [31:0]       WrData_A,
  input  logic [31:0]       RdData_A,
  output logic              cmp_start,
  input  logic              cmp_done,
  input  logic [LD_AW-1:0]  ld_raddr,
  output logic [31:0]       ld_rdata,
  input  logic              res_we,
  input  logic [RES_AW-1:0] res_waddr,
  input  logic [31:0]       res_wdata
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        last_cmd_q, last_cmd_d;
  logic [31:0]        done_d, addr_d, wdata_d;
  logic [3:0]         we_d;
  logic               cmp_start_d;

  // Read-issue tag travelling alongside the BRAM read latency
  logic               issue_v;
  logic [LD_AW-1:0]   issue_idx;
  logic [READ_LAT:0]  pipe_v;
  logic [LD_AW-1:0]   pipe_idx [READ_LAT+1];

  logic [31:0]        res_rdata;
  logic [31:0]        load_base, store_base;

  assign load_base  = 32'(core_id) * CORE_STRIDE;
  assign store_base = OFFSET + 32'(core_id) * 32'(4 * STORE_WORDS);

  // Next-state and next-output decode; bus outputs are registered
  // NOTE: every output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_cmd_d  = last_cmd_q;
    done_d      = done;
    we_d        = 4'h0;
    addr_d      = 32'd0;
    wdata_d     = 32'd0;
    cmp_start_d = 1'b0;
    issue_v     = 1'b0;
    issue_idx   = '0;

    case (state_q)
      S_IDLE, S_HOLD: begin
        if ((state_q == S_HOLD) && (start == CMD_IDLE)) begin
          state_d    = S_IDLE;
          done_d     = ST_IDLE;
          last_cmd_d = CMD_IDLE;
        end else if ((start != last_cmd_q) && is_work_cmd(start)) begin
          last_cmd_d = start;
          done_d     = ST_IDLE;
          cnt_d      = '0;
          if (start == CMD_LOAD) begin
            state_d = S_LOAD;
          end else if (start == CMD_COMPUTE) begin
            state_d     = S_COMPUTE;
            cmp_start_d = 1'b1;
          end else begin
            state_d = S_STORE;
          end
        end
      end

      S_LOAD: begin
        if (cnt_q == CNT_W'(LOAD_WORDS)) begin
          state_d = S_LDRAIN;
          cnt_d   = '0;
        end else begin
          addr_d    = load_base + 32'({cnt_q, 2'b00});
          issue_v   = 1'b1;
          issue_idx = cnt_q[LD_AW-1:0];
          cnt_d     = cnt_q + 1'b1;
        end
      end

      // Last read is still in flight for READ_LAT cycles
      S_LDRAIN: begin
        if (cnt_q == CNT_W'(READ_LAT - 1)) begin
          done_d  = ST_LOADED;
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_COMPUTE: begin
        if (cmp_done) begin
          done_d  = ST_COMPUTED;
          state_d = S_HOLD;
        end
      end

      S_STORE: begin
        if (cnt_q == CNT_W'(STORE_WORDS)) begin
          state_d = S_SETTLE;
        end else begin
          we_d    = 4'hF;
          addr_d  = store_base + 32'({cnt_q, 2'b00});
          wdata_d = res_rdata;
          cnt_d   = cnt_q + 1'b1;
        end
      end

      S_SETTLE: begin
        done_d  = ST_STORED;
        state_d = S_HOLD;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State, handshake and bus output registers
  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      last_cmd_q <= CMD_IDLE;
      done       <= ST_IDLE;
      WE_A       <= 4'h0;
      Addr_A     <= 32'd0;
      WrData_A   <= 32'd0;
      cmp_start  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_cmd_q <= last_cmd_d;
      done       <= done_d;
      WE_A       <= we_d;
      Addr_A     <= addr_d;
      WrData_A   <= wdata_d;
      cmp_start  <= cmp_start_d;
    end
  end

  // Valid bits of the read delay line; reset kills reads already in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_v <= '0;
    end else begin
      pipe_v <= {pipe_v[READ_LAT-1:0], issue_v};
    end
  end

  // Buffer index carried next to each valid bit
  always_ff @(posedge clk) begin
    pipe_idx[0] <= issue_idx;
    for (int i = 1; i <= READ_LAT; i++) begin
      pipe_idx[i] <= pipe_idx[i-1];
    end
  end

  bcrypt_word_buf #(
    .DEPTH (LOAD_WORDS),
    .AW    (LD_AW)
  ) u_load_buf (
    .clk   (clk),
    .we    (pipe_v[READ_LAT]),
    .waddr (pipe_idx[READ_LAT]),
    .wdata (RdData_A),
    .raddr (ld_raddr),
    .rdata (ld_rdata)
  );

  bcrypt_word_buf #(
    .DEPTH (STORE_WORDS),
    .AW    (RES_AW)
  ) u_res_buf (
    .clk   (clk),
    .we    (res_we),
    .waddr (res_waddr),
    .wdata (res_wdata),
    .raddr (cnt_q[RES_AW-1:0]),
    .rdata (res_rdata)
  );

endmodule
